// File: rtl/amo_data_mem.sv
// Word-addressed data memory with single-cycle loads/stores and a 3-cycle atomic RMW engine.
// Define AMO_LRSC_EN to add LR/SC with a single reservation register.
module amo_data_mem #(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic        req_atomic,
   input  logic [4:0]  amo_op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SWAP = 5'b00001;
   localparam logic [4:0] OP_LR   = 5'b00010;
   localparam logic [4:0] OP_SC   = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00100;
   localparam logic [4:0] OP_OR   = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01100;
   localparam logic [4:0] OP_MIN  = 5'b10000;
   localparam logic [4:0] OP_MAX  = 5'b10100;
   localparam logic [4:0] OP_MINU = 5'b11000;
   localparam logic [4:0] OP_MAXU = 5'b11100;

   typedef enum logic [1:0] {IDLE, AMO_WR, AMO_DONE} state_t;

   logic [31:0]   r_mem [DEPTH];
   state_t        r_state;
   logic [31:0]   r_old;
   logic [31:0]   r_result;
   logic [4:0]    r_op;
   logic [AW-1:0] r_idx;

   logic [AW-1:0] w_idx;
   logic          w_atomic_req;
   logic          w_store_req;
   logic          w_amo_we;
   logic [31:0]   w_amo_res;
   logic [31:0]   w_result;
   logic          w_mem_we;
   logic [AW-1:0] w_mem_idx;
   logic [31:0]   w_mem_wdata;
   logic          w_sc_ok;
   logic          w_unused;

   assign w_idx        = addr[AW+1:2];
   assign w_unused     = &{1'b0, addr[31:AW+2], addr[1:0]};
   assign w_atomic_req = req_valid & req_atomic;
   assign w_store_req  = req_valid & req_write & ~req_atomic;

`ifdef AMO_LRSC_EN
   logic          r_resv_valid;
   logic [AW-1:0] r_resv_idx;

   assign w_sc_ok = r_resv_valid && (r_resv_idx == r_idx);
`else
   assign w_sc_ok = 1'b0;
`endif

   // RMW function on the latched old value; wdata is held by the stalled core.
   always_comb begin
      w_amo_we  = 1'b1;
      w_amo_res = r_old;
      w_result  = r_old;
      case (r_op)
         OP_ADD:  w_amo_res = r_old + wdata;
         OP_SWAP: w_amo_res = wdata;
         OP_XOR:  w_amo_res = r_old ^ wdata;
         OP_OR:   w_amo_res = r_old | wdata;
         OP_AND:  w_amo_res = r_old & wdata;
         OP_MIN:  w_amo_res = ($signed(r_old) < $signed(wdata)) ? r_old : wdata;
         OP_MAX:  w_amo_res = ($signed(r_old) > $signed(wdata)) ? r_old : wdata;
         OP_MINU: w_amo_res = (r_old < wdata) ? r_old : wdata;
         OP_MAXU: w_amo_res = (r_old > wdata) ? r_old : wdata;
`ifdef AMO_LRSC_EN
         OP_LR:   w_amo_we  = 1'b0;
         OP_SC: begin
            w_amo_res = wdata;
            w_amo_we  = w_sc_ok;
            w_result  = {31'd0, ~w_sc_ok};
         end
`endif
         default: w_amo_we = 1'b0;
      endcase
   end

   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_idx   = w_idx;
      w_mem_wdata = wdata;
      if (!reset) begin
         if (r_state == IDLE && w_store_req) begin
            w_mem_we = 1'b1;
         end else if (r_state == AMO_WR && w_amo_we) begin
            w_mem_we    = 1'b1;
            w_mem_idx   = r_idx;
            w_mem_wdata = w_amo_res;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_idx] <= w_mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_old    <= 32'd0;
         r_result <= 32'd0;
         r_op     <= 5'd0;
         r_idx    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_atomic_req) begin
                  r_old   <= r_mem[w_idx];
                  r_op    <= amo_op;
                  r_idx   <= w_idx;
                  r_state <= AMO_WR;
               end
            end
            AMO_WR: begin
               r_result <= w_result;
               r_state  <= AMO_DONE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef AMO_LRSC_EN
   // Any write that lands on the reserved word breaks the reservation.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_resv_valid <= 1'b0;
         r_resv_idx   <= '0;
      end else if (r_state == AMO_WR && r_op == OP_LR) begin
         r_resv_valid <= 1'b1;
         r_resv_idx   <= r_idx;
      end else if (r_state == AMO_WR && r_op == OP_SC) begin
         r_resv_valid <= 1'b0;
      end else if (w_mem_we && w_mem_idx == r_resv_idx) begin
         r_resv_valid <= 1'b0;
      end
   end
`endif

   assign stall = (r_state == AMO_WR) || (r_state == IDLE && w_atomic_req && !reset);
   assign rdata = (r_state == AMO_DONE) ? r_result : r_mem[w_idx];

endmodule
